// File: rtl/diod_pkg.sv
// Shared state encoding and index widths for the bias sweep sequencer.
// Used by the sequencer, its noise counter and the bench.
package diod_pkg;

  localparam int STATE_W = 3;
  localparam int WIN_W   = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    SPI_WAIT = 3'd2,
    SETTLE   = 3'd3,
    COUNT    = 3'd4,
    EVAL     = 3'd5,
    STORE    = 3'd6,
    DONE     = 3'd7
  } state_t;

endpackage

// File: rtl/noise_edge_counter.sv
// Noise pulse counter: optional 2-flop sync (BIAS_SWEEP_NOISE_SYNC_EN),
// rising-edge detect, saturating count. Ports: clk rst_n noise_valid clr en count.
module noise_edge_counter
  import diod_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             noise_valid,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  logic             nv;
  logic             nv_q;
  logic             inc;
  logic [CNT_W-1:0] cnt_q;

`ifdef BIAS_SWEEP_NOISE_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], noise_valid};
    end
  end

  assign nv = sync_q[1];
`else
  assign nv = noise_valid;
`endif

  assign inc = en & nv & ~nv_q & ~(&cnt_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nv_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      nv_q <= nv;
      if (clr) begin
        cnt_q <= '0;
      end else if (inc) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Includes the edge being counted this cycle, so an edge on
  // the last cycle of a window is seen when the window closes.
  assign count = cnt_q + CNT_W'(inc);

endmodule

// File: rtl/bias_sweep_sequencer.sv
// Diode bias sweep controller: steps bias, writes DAC via SPI, settles, counts
// noise windows, stores per-step sums, flags breakdown. Option: BIAS_SWEEP_NOISE_SYNC_EN.
module bias_sweep_sequencer
  import diod_pkg::*;
#(
  parameter logic [7:0] V_START       = 8'd0,
  parameter logic [7:0] V_STEP        = 8'd1,
  parameter logic [7:0] V_MAX         = 8'd255,
  parameter int         SETTLE_CYCLES = 1000,
  parameter int         WINDOW_CYCLES = 5000,
  parameter int         N_WINDOWS     = 3,
  parameter int         THRESH        = 16,
  parameter int         CNT_W         = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  input  logic               noise_valid,
  input  logic               spi_done,
  output logic [7:0]         voltage,
  output logic               spi_start,
  output logic               store_en,
  output logic [7:0]         store_voltage,
  output logic [CNT_W-1:0]   store_count,
  output logic               busy,
  output logic               done,
  output logic               breakdown,
  output logic [WIN_W-1:0]   debug_window_count,
  output logic [STATE_W-1:0] debug_state
);

  localparam int T_MAX =
    (SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES : WINDOW_CYCLES;
  localparam int TMR_W = $clog2(T_MAX + 1);

  localparam logic [TMR_W-1:0] SETTLE_END = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] WIN_END    = TMR_W'(WINDOW_CYCLES - 1);
  localparam logic [WIN_W-1:0] LAST_WIN   = WIN_W'(N_WINDOWS - 1);
  localparam logic [CNT_W-1:0] THR        = CNT_W'(THRESH);

  // Release of reset is retimed so the FSM wakes on the 2nd edge.
  logic arm_q;
  logic rst_i;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      arm_q <= 1'b0;
    end else begin
      arm_q <= 1'b1;
    end
  end

  assign rst_i = arm_q;

  state_t           state_q, state_n;
  logic [TMR_W-1:0] tmr_q, tmr_n;
  logic [WIN_W-1:0] win_q, win_n;
  logic [CNT_W-1:0] sum_q, sum_n;
  logic             hit_q, hit_n;
  logic             bdh_q, bdh_n;
  logic [7:0]       volt_n;
  logic             brk_n;
  logic [7:0]       sv_n;
  logic [CNT_W-1:0] sc_n;
  logic             clr;
  logic             en;
  logic [CNT_W-1:0] count;
  logic [8:0]       step;
  logic [CNT_W:0]   wsum;

  noise_edge_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk         (clk),
    .rst_n       (rst_i),
    .noise_valid (noise_valid),
    .clr         (clr),
    .en          (en),
    .count       (count)
  );

  assign step = {1'b0, voltage} + {1'b0, V_STEP};
  assign wsum = {1'b0, sum_q} + {1'b0, count};

  always_comb begin
    state_n = state_q;
    tmr_n   = tmr_q;
    win_n   = win_q;
    sum_n   = sum_q;
    hit_n   = hit_q;
    bdh_n   = bdh_q;
    volt_n  = voltage;
    brk_n   = breakdown;
    sv_n    = store_voltage;
    sc_n    = store_count;
    clr     = 1'b0;
    en      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_n = LOAD;
          volt_n  = V_START;
          brk_n   = 1'b0;
        end
      end
      LOAD: begin
        state_n = SPI_WAIT;
      end
      SPI_WAIT: begin
        if (spi_done) begin
          state_n = SETTLE;
          tmr_n   = '0;
        end
      end
      SETTLE: begin
        if (tmr_q == SETTLE_END) begin
          state_n = COUNT;
          tmr_n   = '0;
          win_n   = '0;
          sum_n   = '0;
          hit_n   = 1'b1;
          clr     = 1'b1;
        end else begin
          tmr_n = tmr_q + 1'b1;
        end
      end
      COUNT: begin
        en = 1'b1;
        if (tmr_q == WIN_END) begin
          sum_n = wsum[CNT_W] ? '1 : wsum[CNT_W-1:0];
          hit_n = hit_q & (count >= THR);
          clr   = 1'b1;
          tmr_n = '0;
          if (win_q == LAST_WIN) begin
            state_n = EVAL;
          end else begin
            win_n = win_q + 1'b1;
          end
        end else begin
          tmr_n = tmr_q + 1'b1;
        end
      end
      EVAL: begin
        bdh_n   = hit_q;
        sv_n    = voltage;
        sc_n    = sum_q;
        state_n = STORE;
      end
      STORE: begin
        if (bdh_q) begin
          state_n = DONE;
          brk_n   = 1'b1;
        end else if (step > {1'b0, V_MAX}) begin
          state_n = DONE;
          brk_n   = 1'b0;
        end else begin
          state_n = LOAD;
          volt_n  = step[7:0];
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    if (abort && state_q != IDLE && state_q != DONE) begin
      state_n = DONE;
      brk_n   = 1'b0;
      volt_n  = voltage;
      sv_n    = store_voltage;
      sc_n    = store_count;
    end
  end

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      state_q       <= IDLE;
      tmr_q         <= '0;
      win_q         <= '0;
      sum_q         <= '0;
      hit_q         <= 1'b0;
      bdh_q         <= 1'b0;
      voltage       <= '0;
      breakdown     <= 1'b0;
      store_voltage <= '0;
      store_count   <= '0;
      spi_start     <= 1'b0;
      store_en      <= 1'b0;
      done          <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state_q       <= state_n;
      tmr_q         <= tmr_n;
      win_q         <= win_n;
      sum_q         <= sum_n;
      hit_q         <= hit_n;
      bdh_q         <= bdh_n;
      voltage       <= volt_n;
      breakdown     <= brk_n;
      store_voltage <= sv_n;
      store_count   <= sc_n;
      // Strobes are registered from the next state so they line
      // up with the cycle the FSM spends in that state.
      spi_start     <= (state_n == LOAD);
      store_en      <= (state_n == STORE);
      done          <= (state_n == DONE);
      busy          <= (state_n != IDLE);
    end
  end

  assign debug_state        = state_q;
  assign debug_window_count = win_q;

endmodule

// File: tb/tb_bias_sweep_sequencer.sv
// Scoreboard bench for bias_sweep_sequencer: quiet, breakdown, partial,
// abort, reset mid-settle, and a narrow-counter saturation instance.
module tb_bias_sweep_sequencer;
  import diod_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic        reset_n;
  logic        start_a, abort_a, nv_a, sd_a, spur;
  logic        spi_done_a;
  logic [7:0]  voltage_a, sv_a;
  logic [15:0] sc_a;
  logic        spi_start_a, store_en_a, busy_a, done_a, brk_a;
  logic [1:0]  win_a;
  logic [2:0]  st_a;

  logic        start_b, nv_b, sd_b, b_en;
  logic [7:0]  voltage_b, sv_b;
  logic [3:0]  sc_b;
  logic        spi_start_b, store_en_b, busy_b, done_b, brk_b;
  logic [1:0]  win_b;
  logic [2:0]  st_b;

  assign spi_done_a = sd_a | spur;

  bias_sweep_sequencer #(
    .V_START(8'd10), .V_STEP(8'd5), .V_MAX(8'd30),
    .SETTLE_CYCLES(4), .WINDOW_CYCLES(20), .N_WINDOWS(3),
    .THRESH(4), .CNT_W(16)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a),
    .abort(abort_a), .noise_valid(nv_a),
    .spi_done(spi_done_a), .voltage(voltage_a),
    .spi_start(spi_start_a), .store_en(store_en_a),
    .store_voltage(sv_a), .store_count(sc_a),
    .busy(busy_a), .done(done_a), .breakdown(brk_a),
    .debug_window_count(win_a), .debug_state(st_a)
  );

  bias_sweep_sequencer #(
    .V_START(8'd10), .V_STEP(8'd5), .V_MAX(8'd30),
    .SETTLE_CYCLES(4), .WINDOW_CYCLES(40), .N_WINDOWS(3),
    .THRESH(4), .CNT_W(4)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b),
    .abort(1'b0), .noise_valid(nv_b),
    .spi_done(sd_b), .voltage(voltage_b),
    .spi_start(spi_start_b), .store_en(store_en_b),
    .store_voltage(sv_b), .store_count(sc_b),
    .busy(busy_b), .done(done_b), .breakdown(brk_b),
    .debug_window_count(win_b), .debug_state(st_b)
  );

  task automatic chk(input string name, input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboards: {voltage, count} per store, {breakdown, voltage} per done.
  logic [23:0] exp_st_a[$];
  logic [8:0]  exp_dn_a[$];
  logic [23:0] exp_st_b[$];
  logic [8:0]  exp_dn_b[$];

  initial begin
    forever begin
      @(negedge clk);
      if (store_en_a) begin
        if (exp_st_a.size() == 0) begin
          chk("a_unexpected_store_v", sv_a, 999);
        end else begin
          logic [23:0] e;
          e = exp_st_a.pop_front();
          chk("a_store_voltage", sv_a, e[23:16]);
          chk("a_store_count", sc_a, e[15:0]);
        end
      end
      if (done_a) begin
        if (exp_dn_a.size() == 0) begin
          chk("a_unexpected_done", 1, 0);
        end else begin
          logic [8:0] d;
          d = exp_dn_a.pop_front();
          chk("a_done_breakdown", brk_a, d[8]);
          chk("a_done_voltage", voltage_a, d[7:0]);
        end
      end
      if (store_en_b) begin
        if (exp_st_b.size() == 0) begin
          chk("b_unexpected_store_v", sv_b, 999);
        end else begin
          logic [23:0] e;
          e = exp_st_b.pop_front();
          chk("b_store_voltage", sv_b, e[23:16]);
          chk("b_store_count", sc_b, e[15:0]);
        end
      end
      if (done_b) begin
        if (exp_dn_b.size() == 0) begin
          chk("b_unexpected_done", 1, 0);
        end else begin
          logic [8:0] d;
          d = exp_dn_b.pop_front();
          chk("b_done_breakdown", brk_b, d[8]);
          chk("b_done_voltage", voltage_b, d[7:0]);
        end
      end
    end
  end

  // SPI master models: done pulse a few cycles after each request.
  initial begin
    logic [3:0] pa, pb;
    pa = '0;
    pb = '0;
    sd_a = 1'b0;
    sd_b = 1'b0;
    forever begin
      @(negedge clk);
      pa = {pa[2:0], spi_start_a};
      pb = {pb[2:0], spi_start_b};
      sd_a = pa[3];
      sd_b = pb[3];
    end
  end

  // Noise stimulus. Pulse slots 2,6,10,14,19 in a 20-cycle window;
  // slot 19 is the window's last cycle.
  int mode = 0;

  function automatic int npulses(input int m, input int v,
                                 input int w);
    if (m == 1) return (v >= 20) ? 5 : 0;
    if (m == 2) return (v == 15) ? ((w == 2) ? 2 : 5) : 0;
    return 0;
  endfunction

  function automatic int slot(input int p);
    case (p)
      2:  return 0;
      6:  return 1;
      10: return 2;
      14: return 3;
      19: return 4;
      default: return 9;
    endcase
  endfunction

  initial begin
    int pos;
    int pwin;
    bit in_cnt;
    pos = 0;
    pwin = 0;
    in_cnt = 0;
    nv_a = 1'b0;
    nv_b = 1'b0;
    forever begin
      @(negedge clk);
      if (st_a == COUNT) begin
        if (!in_cnt || int'(win_a) != pwin) pos = 0;
        else pos++;
        in_cnt = 1;
        pwin = int'(win_a);
        nv_a = slot(pos) < npulses(mode, int'(voltage_a),
                                   int'(win_a));
      end else begin
        in_cnt = 0;
        nv_a = 1'b0;
      end
      nv_b = b_en ? ~nv_b : 1'b0;
    end
  end

  task automatic start_a_task(input bit with_abort);
    @(negedge clk);
    start_a = 1'b1;
    abort_a = with_abort;
    @(negedge clk);
    start_a = 1'b0;
    abort_a = 1'b0;
    chk("start_spi_start", spi_start_a, 1);
    chk("start_voltage", voltage_a, 10);
    chk("start_busy", busy_a, 1);
  endtask

  task automatic wait_done_a(input string name);
    int n;
    n = 0;
    while (!done_a && n < 1500) begin
      @(negedge clk);
      n++;
    end
    chk(name, done_a, 1);
    @(negedge clk);
  endtask

  task automatic wait_state_a(input string name, input state_t s,
                              input int v);
    int n;
    n = 0;
    while (!(st_a == s && int'(voltage_a) == v) && n < 1500) begin
      @(negedge clk);
      n++;
    end
    chk(name, (st_a == s && int'(voltage_a) == v), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    start_a = 1'b0;
    abort_a = 1'b0;
    start_b = 1'b0;
    spur = 1'b0;
    b_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_voltage", voltage_a, 0);
    chk("rst_store_voltage", sv_a, 0);
    chk("rst_store_count", sc_a, 0);
    chk("rst_spi_start", spi_start_a, 0);
    chk("rst_store_en", store_en_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_breakdown", brk_a, 0);
    chk("rst_window", win_a, 0);
    chk("rst_state", st_a, 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // Quiet sweep
    mode = 0;
    for (int v = 10; v <= 30; v += 5) exp_st_a.push_back({8'(v), 16'd0});
    exp_dn_a.push_back({1'b0, 8'd30});
    start_a_task(1'b0);
    wait_done_a("quiet_done");
    chk("quiet_idle", st_a, 0);

    // Breakdown from 20; start and abort together in IDLE
    mode = 1;
    exp_st_a.push_back({8'd10, 16'd0});
    exp_st_a.push_back({8'd15, 16'd0});
    exp_st_a.push_back({8'd20, 16'd15});
    exp_dn_a.push_back({1'b1, 8'd20});
    start_a_task(1'b1);
    wait_done_a("bd_done");
    chk("bd_held", brk_a, 1);
    chk("bd_voltage_held", voltage_a, 20);

    // Partial hit at 15
    mode = 2;
    exp_st_a.push_back({8'd10, 16'd0});
    exp_st_a.push_back({8'd15, 16'd12});
    for (int v = 20; v <= 30; v += 5) exp_st_a.push_back({8'(v), 16'd0});
    exp_dn_a.push_back({1'b0, 8'd30});
    start_a_task(1'b0);
    chk("bd_cleared_on_start", brk_a, 0);
    wait_done_a("partial_done");

    // Abort during COUNT at 15, then restart at 10
    mode = 0;
    exp_st_a.push_back({8'd10, 16'd0});
    exp_dn_a.push_back({1'b0, 8'd15});
    start_a_task(1'b0);
    wait_state_a("abort_reach_count", COUNT, 15);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    chk("abort_done_next", done_a, 1);
    chk("abort_brk", brk_a, 0);
    @(negedge clk);
    chk("abort_idle", st_a, 0);
    exp_dn_a.push_back({1'b0, 8'd10});
    start_a_task(1'b0);
    wait_state_a("abort2_reach_settle", SETTLE, 10);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    chk("abort2_done_next", done_a, 1);
    @(negedge clk);

    // Reset mid-SETTLE, then a stray spi_done in IDLE
    start_a_task(1'b0);
    wait_state_a("rst_reach_settle", SETTLE, 10);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_voltage", voltage_a, 0);
    chk("midrst_state", st_a, 0);
    chk("midrst_busy", busy_a, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    @(negedge clk);
    chk("spur_state", st_a, 0);
    chk("spur_busy", busy_a, 0);

    // Saturation on the 4-bit instance
    b_en = 1'b1;
    exp_st_b.push_back({8'd10, 16'd15});
    exp_dn_b.push_back({1'b1, 8'd10});
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    begin
      int n;
      n = 0;
      while (!done_b && n < 1500) begin
        @(negedge clk);
        n++;
      end
      chk("sat_done", done_b, 1);
    end
    @(negedge clk);
    b_en = 1'b0;
    repeat (2) @(negedge clk);

    chk("a_store_queue_empty", exp_st_a.size(), 0);
    chk("a_done_queue_empty", exp_dn_a.size(), 0);
    chk("b_store_queue_empty", exp_st_b.size(), 0);
    chk("b_done_queue_empty", exp_dn_b.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
